// File: rtl/busy_start_queue.sv
// busy_start_queue: collects single-cycle request pulses into a pending count
// and issues them one at a time as a held start level to a downstream busy
// counter. Requests that arrive while the queue is full are dropped and
// counted for debug.
//
// Legal parameter range: 1 <= MAX_PENDING <= 2**CW-1.
module busy_start_queue #(
    parameter int unsigned CW          = 4,
    parameter int unsigned MAX_PENDING = 15,
    parameter int unsigned DW          = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_req,
    input  logic          i_busy,
    output logic          o_start,
    output logic [CW-1:0] o_pending,
    output logic          o_full,
    output logic          o_overflow,
    input  logic          i_clr_ovf,
    output logic [DW-1:0] o_drops
);

    localparam logic [CW-1:0] MaxPend = CW'(MAX_PENDING);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] drops_q, drops_d;

    logic accept;
    logic inc;
    logic dec;
    logic drop;

    // Handshake and queue bookkeeping terms, all from current register values
    always_comb begin
        o_full = (pending_q == MaxPend);
        accept = o_start && !i_busy;
        dec    = accept;
        // A request while full still fits when the head leaves on the same edge
        inc    = i_req && (!o_full || accept);
        drop   = i_req && o_full && !accept;
    end

    // Pending count next value; inc and dec together net zero
    always_comb begin
        pending_d = pending_q;
        unique case ({inc, dec})
            2'b10:   pending_d = pending_q + CW'(1);
            2'b01:   pending_d = pending_q - CW'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Sticky overflow and saturating drop counter; clear beats a same-cycle drop
    always_comb begin
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (i_clr_ovf) begin
            ovf_d   = 1'b0;
            drops_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drops_q != {DW{1'b1}}) begin
                drops_d = drops_q + DW'(1);
            end
        end
    end

    // FSM next state: hold ISSUE until accepted, then one forced GAP cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (pending_d != '0) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = (pending_d != '0) ? StIssue : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs decoded straight from the state flop
    always_comb begin
        o_start    = (state_q == StIssue);
        o_pending  = pending_q;
        o_overflow = ovf_q;
        o_drops    = drops_q;
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            drops_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            drops_q   <= drops_d;
        end
    end

endmodule

// File: tb/tb_busy_start_queue.sv
// Self-checking bench for busy_start_queue. The reference model tracks the
// queue as plain integers and the start line as "held until accepted, then
// low for at least one cycle".
module tb_busy_start_queue;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_req;
    logic       i_busy;
    logic       i_clr_ovf;
    logic       o_start;
    logic [3:0] o_pending;
    logic       o_full;
    logic       o_overflow;
    logic [7:0] o_drops;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pending;
    bit m_start;
    bit m_ovf;
    int m_drops;

    busy_start_queue #(
        .CW         (4),
        .MAX_PENDING(15),
        .DW         (8)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_req),
        .i_busy    (i_busy),
        .o_start   (o_start),
        .o_pending (o_pending),
        .o_full    (o_full),
        .o_overflow(o_overflow),
        .i_clr_ovf (i_clr_ovf),
        .o_drops   (o_drops)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [14:0] model_vec();
        logic [3:0] p;
        logic [7:0] d;
        p = m_pending[3:0];
        d = m_drops[7:0];
        return {m_start, p, (m_pending == 15), m_ovf, d};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {o_start, o_pending, o_full, o_overflow, o_drops};
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_start   = 0;
        m_ovf     = 0;
        m_drops   = 0;
    endtask

    // Drive one cycle of inputs, advance the model from pre-edge values,
    // then settle just after the edge.
    task automatic step(input bit req, input bit busy, input bit clr);
        bit full, acc, drop, inc;
        int np;
        bit ns;
        i_req     = req;
        i_busy    = busy;
        i_clr_ovf = clr;
        full = (m_pending == 15);
        acc  = m_start && !busy;
        drop = req && full && !acc;
        inc  = req && (!full || acc);
        np   = m_pending + int'(inc) - int'(acc);
        ns   = m_start ? !acc : (np != 0);
        @(posedge i_clk);
        #1;
        m_pending = np;
        m_start   = ns;
        if (clr) begin
            m_ovf   = 0;
            m_drops = 0;
        end else if (drop) begin
            m_ovf = 1;
            if (m_drops < 255) m_drops = m_drops + 1;
        end
    endtask

    task automatic apply_reset();
        i_req     = 1'b0;
        i_busy    = 1'b0;
        i_clr_ovf = 1'b0;
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (o_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_start got %b want 0", o_start);
        end
        n_checks++;
        if (o_pending !== 4'd0) begin
            n_fail++; $display("FAIL reset_pending got %0d want 0", o_pending);
        end
        n_checks++;
        if (o_overflow !== 1'b0 || o_drops !== 8'd0 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_debug got ovf=%b drops=%0d full=%b want 0/0/0",
                     o_overflow, o_drops, o_full);
        end
    endtask

    task automatic test_single();
        apply_reset();
        step(1, 0, 0);
        n_checks++;
        if (o_start !== 1'b1 || o_pending !== 4'd1) begin
            n_fail++;
            $display("FAIL single_issue got start=%b pend=%0d want 1/1", o_start, o_pending);
        end
        step(0, 0, 0);
        n_checks++;
        if (o_start !== 1'b0 || o_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL single_gap got start=%b pend=%0d want 0/0", o_start, o_pending);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL single_idle got %h want %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int  busy_cnt = 0;
        int  episodes = 0;
        bit  prev_start = 0;
        bit  busy, acc;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            acc = o_start && !busy;
            step(c < 3, busy, 0);
            if (acc) busy_cnt = 5;
            if (o_start && !prev_start) episodes++;
            prev_start = o_start;
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d got %h want %h", c, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (episodes != 3 || o_pending !== 4'd0) begin
            n_fail++;
            $display("FAIL b2b_episodes got %0d pend=%0d want 3/0", episodes, o_pending);
        end
    endtask

    // Continues into test_full_accept with the queue left full
    task automatic test_full_drops();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            step(1, 1, 0);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL fill_cycle%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (o_pending !== 4'd15 || o_full !== 1'b1 || o_overflow !== 1'b1 ||
            o_drops !== 8'd2 || o_start !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drops got pend=%0d full=%b ovf=%b drops=%0d start=%b want 15/1/1/2/1",
                     o_pending, o_full, o_overflow, o_drops, o_start);
        end
    endtask

    task automatic test_full_accept();
        step(1, 0, 0);
        n_checks++;
        if (o_pending !== 4'd15 || o_drops !== 8'd2 || o_overflow !== 1'b1 ||
            o_start !== 1'b0) begin
            n_fail++;
            $display("FAIL full_accept got pend=%0d drops=%0d ovf=%b start=%b want 15/2/1/0",
                     o_pending, o_drops, o_overflow, o_start);
        end
        step(0, 1, 0);
        n_checks++;
        if (o_start !== 1'b1 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL gap_to_issue got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_drop_saturation();
        apply_reset();
        for (int i = 0; i < 15 + 255; i++) step(1, 1, 0);
        n_checks++;
        if (o_drops !== 8'd255 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL drops_reach_max got drops=%0d want 255", o_drops);
        end
        step(1, 1, 0);
        n_checks++;
        if (o_drops !== 8'd255) begin
            n_fail++;
            $display("FAIL drops_saturate got %0d want 255", o_drops);
        end
        step(1, 1, 1);
        n_checks++;
        if (o_drops !== 8'd0 || o_overflow !== 1'b0 || o_pending !== 4'd15) begin
            n_fail++;
            $display("FAIL clr_priority got drops=%0d ovf=%b pend=%0d want 0/0/15",
                     o_drops, o_overflow, o_pending);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0);
        n_checks++;
        if (o_start !== 1'b1 || o_pending !== 4'd4) begin
            n_fail++;
            $display("FAIL pre_reset got start=%b pend=%0d want 1/4", o_start, o_pending);
        end
        i_reset_n = 1'b0;
        #2;
        n_checks++;
        if (o_start !== 1'b0 || o_pending !== 4'd0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got start=%b pend=%0d ovf=%b want 0/0/0",
                     o_start, o_pending, o_overflow);
        end
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 1'($urandom_range(0, 1)), 0);
            n_checks++;
            if (o_start !== 1'b0 || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL post_reset_idle got %h want %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        bit req, busy, clr;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            req  = ($urandom_range(0, 99) < 60);
            // Alternate busy-heavy and busy-light phases so the queue both fills and drains
            busy = ((c / 100) % 2 == 0) ? ($urandom_range(0, 99) < 85)
                                        : ($urandom_range(0, 99) < 20);
            clr  = ($urandom_range(0, 31) == 0);
            step(req, busy, clr);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d got %h want %h", c, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_req     = 1'b0;
        i_busy    = 1'b0;
        i_clr_ovf = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_full_drops();
        test_full_accept();
        test_drop_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
